// File: rtl/frame_dispatcher.sv
// frame_dispatcher
//   Holds FRAME_NUM task frames in a synchronous RAM, loaded line by line while
//   prog_loading is high. When loading ends, each frame's payload (lines
//   2..FRAME_LINES-1) is streamed in order to every core in the frame's core
//   mask over one shared valid/ready bus.
//   Header line 0: bit0 = fence, bit1 = last. Header line 1: core mask.
//
//   Optional feature macro: FRAME_DISPATCHER_OOO_EN
//     defined     : SELECT serves the lowest unserved masked core that is ready now.
//     not defined : SELECT serves masked cores in strict ascending order.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   prog_loading      load window; its falling edge starts dispatch
//   load_we/load_data write one line at the load pointer
//   core_ready        per-core idle level
//   core_reading      bus ready from the addressed core
//   out_valid/out_data/out_core/out_first/out_last  payload bus
//   frame_being_sent  high from a frame's first beat to its last accepted beat
//   cur_frame         index of the frame being dispatched
//   dispatch_done     sticky, set on entering DONE
//   load_overflow     sticky, a write hit past the end of RAM
module frame_dispatcher #(
  parameter int INSTR_SIZE  = 16,
  parameter int CORE_NUM    = 16,
  parameter int FRAME_LINES = 48,
  parameter int FRAME_NUM   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         prog_loading,
  input  logic                         load_we,
  input  logic [INSTR_SIZE-1:0]        load_data,
  input  logic [CORE_NUM-1:0]          core_ready,
  input  logic                         core_reading,
  output logic                         out_valid,
  output logic [INSTR_SIZE-1:0]        out_data,
  output logic [CORE_NUM-1:0]          out_core,
  output logic                         out_first,
  output logic                         out_last,
  output logic                         frame_being_sent,
  output logic [$clog2(FRAME_NUM)-1:0] cur_frame,
  output logic                         dispatch_done,
  output logic                         load_overflow
);
  localparam int DEPTH = FRAME_NUM * FRAME_LINES;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = $clog2(DEPTH + 1);
  localparam int FW    = $clog2(FRAME_NUM);
  // two spare codes so the prefetch line index (beat+2) never wraps
  localparam int LW    = $clog2(FRAME_LINES + 2);
  localparam logic [LW-1:0] LMAX = LW'(FRAME_LINES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_HDR, S_FENCE, S_SELECT, S_STREAM, S_NEXT, S_DONE
  } state_t;

  function automatic logic [AW-1:0] line_addr(input logic [FW-1:0] f, input logic [LW-1:0] l);
    return AW'(int'(f) * FRAME_LINES + int'(l));
  endfunction

  // isolate the lowest set bit
  function automatic logic [CORE_NUM-1:0] lowest(input logic [CORE_NUM-1:0] v);
    return v & (~v + CORE_NUM'(1));
  endfunction

  state_t                state_q, state_d;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic                  fence_q, fence_d, last_q, last_d;
  logic [CORE_NUM-1:0]   mask_q, mask_d, served_q, served_d;
  logic                  mask_pend_q, mask_pend_d;
  logic [FW-1:0]         cur_frame_q, cur_frame_d;
  logic [LW-1:0]         beat_q, beat_d;
  logic                  out_valid_q, out_valid_d, out_first_q, out_first_d, out_last_q, out_last_d;
  logic [INSTR_SIZE-1:0] out_data_q, out_data_d;
  logic [CORE_NUM-1:0]   out_core_q, out_core_d;
  logic                  fbs_q, fbs_d, done_q, done_d, ovf_q, ovf_d;

  logic [INSTR_SIZE-1:0] ram [DEPTH];
  logic [INSTR_SIZE-1:0] ram_q;
  logic [AW-1:0]         rd_addr, wr_addr;
  logic                  ram_we;
  logic [FW-1:0]         rd_frame;
  logic [LW-1:0]         rd_line;
  logic [CORE_NUM-1:0]   pending, pick;
  logic                  accept, enter_load;
  logic [PW-1:0]         base;

  assign rd_addr = line_addr(rd_frame, (rd_line > LMAX) ? LMAX : rd_line);

  // RAM is never cleared; the read port re-reads the same address while the
  // bus stalls, so ram_q always holds the line after the one on the bus.
  always_ff @(posedge clk) begin
    if (ram_we) ram[wr_addr] <= load_data;
    ram_q <= ram[rd_addr];
  end

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    fence_d     = fence_q;
    last_d      = last_q;
    mask_d      = mask_q;
    served_d    = served_q;
    mask_pend_d = mask_pend_q;
    cur_frame_d = cur_frame_q;
    beat_d      = beat_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_core_d  = out_core_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    fbs_d       = fbs_q;
    done_d      = done_q;
    ovf_d       = ovf_q;
    ram_we      = 1'b0;
    wr_addr     = '0;
    base        = wptr_q;
    rd_frame    = cur_frame_q;
    rd_line     = LW'(2);
    enter_load  = 1'b0;
    accept      = out_valid_q && core_reading;
    pending     = mask_q & ~served_q;
`ifdef FRAME_DISPATCHER_OOO_EN
    pick        = lowest(pending & core_ready);
`else
    // only the head of the ascending order may go, and only when it is ready
    pick        = lowest(pending) & core_ready;
`endif

    case (state_q)
      S_IDLE: if (prog_loading) begin
        state_d    = S_LOAD;
        enter_load = 1'b1;
      end
      S_LOAD: if (!prog_loading) begin
        state_d     = S_HDR;
        cur_frame_d = '0;
        rd_frame    = '0;
        rd_line     = '0;
      end
      S_HDR: begin
        fence_d     = ram_q[0];
        last_d      = ram_q[1];
        served_d    = '0;
        mask_pend_d = 1'b1;
        rd_line     = LW'(1);
        state_d     = S_FENCE;
      end
      S_FENCE: begin
        // the mask line lands in ram_q during the first FENCE cycle
        if (mask_pend_q) begin
          mask_d      = ram_q[CORE_NUM-1:0];
          mask_pend_d = 1'b0;
        end
        if (!fence_q || &core_ready) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (pending == '0) begin
          state_d = S_NEXT;
        end else if (pick != '0) begin
          // ram_q already holds payload line 2
          state_d     = S_STREAM;
          out_valid_d = 1'b1;
          out_data_d  = ram_q;
          out_core_d  = pick;
          out_first_d = 1'b1;
          out_last_d  = (FRAME_LINES == 3);
          fbs_d       = 1'b1;
          beat_d      = LW'(2);
          rd_line     = LW'(3);
        end
      end
      S_STREAM: begin
        rd_line = beat_q + LW'(1);
        if (accept) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_core_d  = '0;
            out_first_d = 1'b0;
            out_last_d  = 1'b0;
            served_d    = served_q | out_core_q;
            fbs_d       = |(pending & ~out_core_q);
            state_d     = S_SELECT;
            rd_line     = LW'(2);
          end else begin
            out_data_d  = ram_q;
            out_first_d = 1'b0;
            out_last_d  = (beat_q == LW'(FRAME_LINES - 2));
            beat_d      = beat_q + LW'(1);
            rd_line     = beat_q + LW'(2);
          end
        end
      end
      S_NEXT: begin
        if (last_q || cur_frame_q == FW'(FRAME_NUM - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          cur_frame_d = cur_frame_q + FW'(1);
          rd_frame    = cur_frame_q + FW'(1);
          rd_line     = '0;
          state_d     = S_HDR;
        end
      end
      S_DONE: if (prog_loading) begin
        state_d    = S_LOAD;
        enter_load = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // the cycle that opens a load window restarts the write pointer
    if (enter_load) base = '0;
    if (load_we && (state_q == S_IDLE || state_q == S_LOAD)) begin
      if (base < PW'(DEPTH)) begin
        ram_we  = 1'b1;
        wr_addr = AW'(base);
        wptr_d  = base + PW'(1);
      end else begin
        ovf_d  = 1'b1;
        wptr_d = base;
      end
    end else if (enter_load) begin
      wptr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      fence_q     <= 1'b0;
      last_q      <= 1'b0;
      mask_q      <= '0;
      served_q    <= '0;
      mask_pend_q <= 1'b0;
      cur_frame_q <= '0;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_core_q  <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      fbs_q       <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      fence_q     <= fence_d;
      last_q      <= last_d;
      mask_q      <= mask_d;
      served_q    <= served_d;
      mask_pend_q <= mask_pend_d;
      cur_frame_q <= cur_frame_d;
      beat_q      <= beat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_core_q  <= out_core_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      fbs_q       <= fbs_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign out_data         = out_data_q;
  assign out_core         = out_core_q;
  assign out_first        = out_first_q;
  assign out_last         = out_last_q;
  assign frame_being_sent = fbs_q;
  assign cur_frame        = cur_frame_q;
  assign dispatch_done    = done_q;
  assign load_overflow    = ovf_q;
endmodule
